cpu_fetch_hq: RTL and testbench
===============================

// Module: cpu_fetch_hq
// PURPOSE
//  Next-gen moxie fetch unit: parametrised halfword instruction queue, req/ack imem port.
//  Assembles 16-bit opcodes plus optional 32-bit operand from a big-endian 32-bit word stream.
//  Supports halfword-aligned branch targets; presents instructions to decode with valid/ready.
//  Sits between instruction memory/cache and cpu_decode.
// PARAMETERS
//  BOOT_ADDRESS  32'h00001000  PC loaded on reset
//  QDEPTH_LOG2   3             queue depth = 2**QDEPTH_LOG2 halfwords; legal 3..6
//  LONG_MASK     64'h0         bit n set: form-1 opcode (op[15:14]==2'b00, op[13:8]==n) carries 32-bit operand
// PORTS
//  clk_i          in   1   clock
//  rst_n_i        in   1   asynchronous active-low reset
//  imem_req_o     out  1   fetch request; held until imem_ack_i
//  imem_address_o out  32  word address, bits[1:0]==0
//  imem_ack_i     in   1   data valid for current request
//  imem_data_i    in   32  fetched word; [31:16] is lower-addressed halfword
//  branch_flag_i  in   1   redirect fetch this cycle
//  branch_target_i in  32  redirect address, bit0 ignored (treated 0)
//  inst_ready_i   in   1   decode accepts instruction
//  valid_o        out  1   opcode_o/operand_o/pc_o hold a complete instruction
//  opcode_o       out  16  instruction halfword
//  operand_o      out  32  immediate; 0 for short instructions
//  pc_o           out  32  address of opcode_o
// BEHAVIOUR
//  Reset (async): imem_req_o=0, imem_address_o=BOOT_ADDRESS&~3, valid_o=0, opcode_o=0,
//   operand_o=0, pc_o=BOOT_ADDRESS, queue empty, discard flag clear, skip_hi=BOOT_ADDRESS[1].
//  Queue: circular, halfword entries, count 0..2**QDEPTH_LOG2; pointers wrap modulo depth.
//  Request: at most one outstanding. Assert req when not outstanding and free slots >= 2.
//   Address advances +4 on each accepted ack.
//  Ack push: push [31:16] then [15:0]; if skip_hi, push only [15:0] and clear skip_hi.
//  Length: long iff op[15:14]==0 && LONG_MASK[op[13:8]]; long needs 3 halfwords queued.
//  valid_o combinational from queue head: 1 when head instruction fully present.
//  Transfer on valid_o && inst_ready_i: pop 1 (short) or 3 (long) halfwords; pc_o += 2 or 6.
//  Push and pop in the same cycle are both performed; count updates by net difference.
//  Latency: redirect -> req next cycle; ack -> valid_o next cycle (short).
//  Branch (highest priority): queue flushed, valid_o=0 next cycle, fetch addr=target&~3,
//   pc_o=target&~1, skip_hi=target[1]. Outstanding request: discard flag set and its ack is
//   dropped; no new req until that ack. Ack in the branch cycle is dropped.
//   Pop in the branch cycle is ignored.
//  Back-to-back branches: last wins; the discard flag stays set until one ack is received.
//  Full queue: no req; stalled decode never loses entries.
//  Wrap: address 32'hFFFFFFFC + 4 -> 0; pc_o wraps modulo 2**32.
// CONFIGURATION
//  CPU_FETCH_PERF_EN defined: adds outputs
//   flush_cnt_o out 16 (branches taken) and bubble_cnt_o out 16 (cycles inst_ready_i=1,
//   valid_o=0). Both saturate at 16'hFFFF and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset; ack words 32'h0100_0200, 32'h0300_0400 with ready=1 -> opcodes 0100,0200,0300,0400
//    at pc 1000,1002,1004,1006.
//  2 LONG_MASK bit1 set; words 32'h0100_DEAD, 32'hBEEF_0500 -> opcode 0100 with
//    operand DEADBEEF at pc 1000, then 0500 at pc 1006.
//  3 inst_ready_i=0 with QDEPTH_LOG2=3 -> req stops after 4 acks, count=8; release ->
//    8 halfwords delivered in order.
//  4 Branch to 32'h2002 while request outstanding -> in-flight ack dropped; next req addr 2000;
//    ack 32'hAAAA_BBBB -> opcode BBBB at pc 2002.
//  5 Branch same cycle as ack and pop -> both ignored; valid_o=0 next cycle.
//  6 rst_n_i low mid-request, no clock edge -> outputs at reset values immediately;
//    first req addr 1000.
//  6a With CPU_FETCH_PERF_EN: 3 branches -> flush_cnt_o=3.

Source files
------------

// File: rtl/cpu_fetch_hq_if.sv
// ----------------------------------------------------------------------------
// cpu_fetch_hq_if
//   Bundles the fetch unit's instruction-memory port, redirect input and the
//   instruction hand-off to decode.
//
//   master : the fetch unit (drives imem request/address and the instruction)
//   slave  : the surroundings (memory, branch unit, decode)
//
//   imem_req_o      fetch request, held until imem_ack_i
//   imem_address_o  word address of the request (bits[1:0] == 0)
//   imem_ack_i      imem_data_i valid for the current request
//   imem_data_i     fetched word, [31:16] is the lower-addressed halfword
//   branch_flag_i   redirect fetch this cycle
//   branch_target_i redirect address (bit 0 ignored)
//   inst_ready_i    decode accepts the presented instruction
//   valid_o         opcode_o/operand_o/pc_o hold a complete instruction
//   opcode_o        instruction halfword
//   operand_o       32-bit immediate, 0 for short instructions
//   pc_o            address of opcode_o
// ----------------------------------------------------------------------------
interface cpu_fetch_hq_if;
    logic        imem_req_o;
    logic [31:0] imem_address_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        inst_ready_i;
    logic        valid_o;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o, imem_address_o, valid_o, opcode_o, operand_o, pc_o,
        input  imem_ack_i, imem_data_i, branch_flag_i, branch_target_i, inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_address_o, valid_o, opcode_o, operand_o, pc_o,
        output imem_ack_i, imem_data_i, branch_flag_i, branch_target_i, inst_ready_i
    );
endinterface

// File: rtl/cpu_fetch_hq.sv
// ----------------------------------------------------------------------------
// cpu_fetch_hq
//   Moxie fetch unit. Requests 32-bit big-endian words from instruction
//   memory (one request outstanding at most), splits them into halfwords in a
//   circular queue and presents complete instructions (16-bit opcode plus an
//   optional 32-bit operand) to decode with a valid/ready handshake.
//   Branch targets may be halfword aligned; the unused upper halfword of the
//   first fetched word is skipped.
//
// Parameters
//   BOOT_ADDRESS  PC after reset
//   QDEPTH_LOG2   queue holds 2**QDEPTH_LOG2 halfwords (3..6)
//   LONG_MASK     bit n set: opcode with op[15:14]==0 and op[13:8]==n is
//                 followed by a 32-bit operand (two more halfwords)
//
// Ports
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   bus        cpu_fetch_hq_if.master (imem port, redirect, decode hand-off)
//   flush_cnt_o, bubble_cnt_o  (only with CPU_FETCH_PERF_EN) saturating
//              counts of redirects and of cycles decode was ready but no
//              instruction was valid
//
// Build option
//   CPU_FETCH_PERF_EN  adds the two performance counters above.
// ----------------------------------------------------------------------------
module cpu_fetch_hq #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
    parameter int          QDEPTH_LOG2  = 3,
    parameter logic [63:0] LONG_MASK    = 64'h0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    cpu_fetch_hq_if.master bus
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [15:0]    flush_cnt_o,
    output logic [15:0]    bubble_cnt_o
`endif
);
    localparam int             AW      = QDEPTH_LOG2;
    localparam int             CW      = QDEPTH_LOG2 + 1;
    localparam int             DEPTH   = 2 ** QDEPTH_LOG2;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

`ifdef CPU_FETCH_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    logic [15:0]   q_mem [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW-1:0] rd_p1, rd_p2, wr_p1;
    logic [CW-1:0] count_q, count_nx;
    logic [CW-1:0] push_n, pop_n;
    logic          req_q, req_nx;
    logic          discard_q, discard_nx;
    logic          skip_hi_q;
    logic [31:0]   addr_q, pc_q;
    logic          branch, ack_acc, push, pop;

    logic [15:0]   op_p0;
    logic [31:0]   imm_p0;
    logic          long_p0;
    logic          vld_p0;

    // ---- stage p0: instruction at the queue head ----
    always_comb begin
        rd_p1   = rd_ptr_q + AW'(1);
        rd_p2   = rd_ptr_q + AW'(2);
        wr_p1   = wr_ptr_q + AW'(1);
        op_p0   = q_mem[rd_ptr_q];
        imm_p0  = {q_mem[rd_p1], q_mem[rd_p2]};
        long_p0 = (op_p0[15:14] == 2'b00) && LONG_MASK[op_p0[13:8]];
        vld_p0  = long_p0 ? (count_q >= CW'(3)) : (count_q != '0);
    end

    // Queue/request control. A redirect overrides everything: pushes and
    // pops in that cycle are suppressed and the queue is emptied.
    always_comb begin
        branch  = bus.branch_flag_i;
        ack_acc = bus.imem_ack_i && req_q;
        push    = ack_acc && !discard_q && !branch;
        pop     = vld_p0 && bus.inst_ready_i && !branch;

        push_n = '0;
        if (push)
            push_n = skip_hi_q ? CW'(1) : CW'(2);
        pop_n = '0;
        if (pop)
            pop_n = long_p0 ? CW'(3) : CW'(1);

        count_nx = branch ? '0 : (count_q + push_n - pop_n);

        // The ack that completes a request always clears the discard flag;
        // redirecting with a request still in flight marks its data stale.
        if (ack_acc)
            discard_nx = 1'b0;
        else if (branch && req_q)
            discard_nx = 1'b1;
        else
            discard_nx = discard_q;

        // Keep an unanswered request up; otherwise start a new one whenever
        // the post-update queue can absorb a full word.
        req_nx = (req_q && !ack_acc) || ((DEPTH_C - count_nx) >= CW'(2));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q     <= 1'b0;
            discard_q <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            addr_q    <= BOOT_ADDRESS & ~32'h3;
            pc_q      <= BOOT_ADDRESS;
            skip_hi_q <= BOOT_ADDRESS[1];
        end else begin
            req_q     <= req_nx;
            discard_q <= discard_nx;
            count_q   <= count_nx;
            if (branch) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                addr_q    <= bus.branch_target_i & ~32'h3;
                pc_q      <= bus.branch_target_i & ~32'h1;
                skip_hi_q <= bus.branch_target_i[1];
            end else begin
                if (push) begin
                    wr_ptr_q  <= wr_ptr_q + push_n[AW-1:0];
                    addr_q    <= addr_q + 32'd4;
                    skip_hi_q <= 1'b0;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + pop_n[AW-1:0];
                    pc_q     <= pc_q + (long_p0 ? 32'd6 : 32'd2);
                end
            end
        end
    end

    // Queue storage carries data only; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (skip_hi_q) begin
                q_mem[wr_ptr_q] <= bus.imem_data_i[15:0];
            end else begin
                q_mem[wr_ptr_q] <= bus.imem_data_i[31:16];
                q_mem[wr_p1]    <= bus.imem_data_i[15:0];
            end
        end
    end

    assign bus.imem_req_o     = req_q;
    assign bus.imem_address_o = addr_q;
    assign bus.valid_o        = vld_p0;
    assign bus.opcode_o       = vld_p0 ? op_p0 : 16'h0;
    assign bus.operand_o      = (vld_p0 && long_p0) ? imm_p0 : 32'h0;
    assign bus.pc_o           = pc_q;

`ifdef CPU_FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flush_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (branch)
                flush_cnt_o <= sat_inc16(flush_cnt_o);
            if (bus.inst_ready_i && !vld_p0)
                bubble_cnt_o <= sat_inc16(bubble_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_hq.sv
// Bench for cpu_fetch_hq. dut_a uses LONG_MASK=0, dut_b sets bit 1 so that
// opcode 0100 carries an operand. Expected instructions are queued per DUT and
// checked by a monitor whenever an instruction is transferred to decode.
module tb_cpu_fetch_hq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_fetch_hq_if ifa ();
    cpu_fetch_hq_if ifb ();

`ifdef CPU_FETCH_PERF_EN
    logic [15:0] flush_a, bubble_a, flush_b, bubble_b;
`endif

    cpu_fetch_hq #(.BOOT_ADDRESS(32'h0000_1000), .QDEPTH_LOG2(3), .LONG_MASK(64'h0)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa)
`ifdef CPU_FETCH_PERF_EN
        , .flush_cnt_o(flush_a), .bubble_cnt_o(bubble_a)
`endif
    );

    cpu_fetch_hq #(.BOOT_ADDRESS(32'h0000_1000), .QDEPTH_LOG2(3), .LONG_MASK(64'h2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifb)
`ifdef CPU_FETCH_PERF_EN
        , .flush_cnt_o(flush_b), .bubble_cnt_o(bubble_b)
`endif
    );

    typedef struct packed {
        logic [15:0] op;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic exp_a(input logic [15:0] op, input logic [31:0] imm, input logic [31:0] pc);
        qa.push_back(exp_t'({op, imm, pc}));
    endtask

    task automatic exp_b(input logic [15:0] op, input logic [31:0] imm, input logic [31:0] pc);
        qb.push_back(exp_t'({op, imm, pc}));
    endtask

    // Monitors: a transfer happens on valid && ready unless a redirect is present.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifa.valid_o === 1'b1 && ifa.inst_ready_i && !ifa.branch_flag_i) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: got opcode %0h pc %0h expected none", ifa.opcode_o, ifa.pc_o);
            end else begin
                ea = qa.pop_front();
                chk("a_opcode",  64'(ifa.opcode_o),  64'(ea.op));
                chk("a_operand", 64'(ifa.operand_o), 64'(ea.imm));
                chk("a_pc",      64'(ifa.pc_o),      64'(ea.pc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifb.valid_o === 1'b1 && ifb.inst_ready_i && !ifb.branch_flag_i) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: got opcode %0h pc %0h expected none", ifb.opcode_o, ifb.pc_o);
            end else begin
                eb = qb.pop_front();
                chk("b_opcode",  64'(ifb.opcode_o),  64'(eb.op));
                chk("b_operand", 64'(ifb.operand_o), 64'(eb.imm));
                chk("b_pc",      64'(ifb.pc_o),      64'(eb.pc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req_a();
        int t = 0;
        while (ifa.imem_req_o !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        chk("a_req_wait", 64'(ifa.imem_req_o), 64'd1);
    endtask

    task automatic ack_a(input logic [31:0] w);
        wait_req_a();
        if (ifa.imem_req_o === 1'b1) begin
            ifa.imem_ack_i  = 1'b1;
            ifa.imem_data_i = w;
            step(1);
            ifa.imem_ack_i  = 1'b0;
        end
    endtask

    task automatic ack_b(input logic [31:0] w);
        int t = 0;
        while (ifb.imem_req_o !== 1'b1 && t < 50) begin
            step(1);
            t++;
        end
        chk("b_req_wait", 64'(ifb.imem_req_o), 64'd1);
        if (ifb.imem_req_o === 1'b1) begin
            ifb.imem_ack_i  = 1'b1;
            ifb.imem_data_i = w;
            step(1);
            ifb.imem_ack_i  = 1'b0;
        end
    endtask

    task automatic drain_a(input string name);
        int t = 0;
        while (qa.size() != 0 && t < 100) begin
            step(1);
            t++;
        end
        chk(name, 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b(input string name);
        int t = 0;
        while (qb.size() != 0 && t < 100) begin
            step(1);
            t++;
        end
        chk(name, 64'(qb.size()), 64'd0);
    endtask

    task automatic branch_a(input logic [31:0] tgt);
        ifa.branch_flag_i   = 1'b1;
        ifa.branch_target_i = tgt;
        step(1);
        ifa.branch_flag_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.imem_ack_i = 1'b0; ifa.imem_data_i = '0; ifa.branch_flag_i = 1'b0;
        ifa.branch_target_i = '0; ifa.inst_ready_i = 1'b0;
        ifb.imem_ack_i = 1'b0; ifb.imem_data_i = '0; ifb.branch_flag_i = 1'b0;
        ifb.branch_target_i = '0; ifb.inst_ready_i = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;

        // Reset state
        chk("rst_req",     64'(ifa.imem_req_o),     64'd0);
        chk("rst_addr",    64'(ifa.imem_address_o), 64'h1000);
        chk("rst_valid",   64'(ifa.valid_o),        64'd0);
        chk("rst_opcode",  64'(ifa.opcode_o),       64'd0);
        chk("rst_operand", 64'(ifa.operand_o),      64'd0);
        chk("rst_pc",      64'(ifa.pc_o),           64'h1000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: short opcodes in order, one instruction per cycle
        ifa.inst_ready_i = 1'b1;
        exp_a(16'h0100, 32'h0, 32'h1000);
        exp_a(16'h0200, 32'h0, 32'h1002);
        exp_a(16'h0300, 32'h0, 32'h1004);
        exp_a(16'h0400, 32'h0, 32'h1006);
        ack_a(32'h0100_0200);
        chk("t1_valid_lat", 64'(ifa.valid_o),  64'd1);
        chk("t1_first_op",  64'(ifa.opcode_o), 64'h0100);
        ack_a(32'h0300_0400);
        drain_a("t1_drain");

        // 2: long opcode waits for its operand halfwords
        ifb.inst_ready_i = 1'b1;
        exp_b(16'h0100, 32'hDEAD_BEEF, 32'h1000);
        exp_b(16'h0500, 32'h0,         32'h1006);
        ack_b(32'h0100_DEAD);
        chk("t2_long_wait", 64'(ifb.valid_o), 64'd0);
        ack_b(32'hBEEF_0500);
        drain_b("t2_drain");

        // 3: stalled decode fills the queue; nothing is lost
        ifa.inst_ready_i = 1'b0;
        exp_a(16'h1111, 32'h0, 32'h1008);
        exp_a(16'h2222, 32'h0, 32'h100A);
        exp_a(16'h3333, 32'h0, 32'h100C);
        exp_a(16'h4444, 32'h0, 32'h100E);
        exp_a(16'h5555, 32'h0, 32'h1010);
        exp_a(16'h6666, 32'h0, 32'h1012);
        exp_a(16'h7777, 32'h0, 32'h1014);
        exp_a(16'h8888, 32'h0, 32'h1016);
        ack_a(32'h1111_2222);
        ack_a(32'h3333_4444);
        ack_a(32'h5555_6666);
        ack_a(32'h7777_8888);
        step(3);
        chk("t3_full_noreq", 64'(ifa.imem_req_o), 64'd0);
        chk("t3_head_pc",    64'(ifa.pc_o),       64'h1008);
        ifa.inst_ready_i = 1'b1;
        drain_a("t3_drain");

        // 4: redirect with a request in flight; its data is discarded
        wait_req_a();
        branch_a(32'h0000_2002);
        chk("t4_valid",    64'(ifa.valid_o),        64'd0);
        chk("t4_pc",       64'(ifa.pc_o),           64'h2002);
        chk("t4_addr",     64'(ifa.imem_address_o), 64'h2000);
        chk("t4_req_held", 64'(ifa.imem_req_o),     64'd1);
        ack_a(32'h9999_9999);
        chk("t4_drop_valid", 64'(ifa.valid_o), 64'd0);
        wait_req_a();
        chk("t4_new_addr", 64'(ifa.imem_address_o), 64'h2000);
        exp_a(16'hBBBB, 32'h0, 32'h2002);
        ack_a(32'hAAAA_BBBB);
        drain_a("t4_drain");

        // 5: redirect in the same cycle as an ack and a pop
        ifa.inst_ready_i = 1'b0;
        ack_a(32'h4000_4001);
        wait_req_a();
        ifa.inst_ready_i    = 1'b1;
        ifa.imem_ack_i      = 1'b1;
        ifa.imem_data_i     = 32'h6000_6001;
        ifa.branch_flag_i   = 1'b1;
        ifa.branch_target_i = 32'h0000_3000;
        step(1);
        ifa.imem_ack_i      = 1'b0;
        ifa.branch_flag_i   = 1'b0;
        chk("t5_valid", 64'(ifa.valid_o),        64'd0);
        chk("t5_pc",    64'(ifa.pc_o),           64'h3000);
        chk("t5_addr",  64'(ifa.imem_address_o), 64'h3000);
        chk("t5_req",   64'(ifa.imem_req_o),     64'd1);
        exp_a(16'h5000, 32'h0, 32'h3000);
        exp_a(16'h5001, 32'h0, 32'h3002);
        ack_a(32'h5000_5001);
        drain_a("t5_drain");

        // 6: asynchronous reset while a request is pending
        wait_req_a();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req",   64'(ifa.imem_req_o),     64'd0);
        chk("t6_addr",  64'(ifa.imem_address_o), 64'h1000);
        chk("t6_valid", 64'(ifa.valid_o),        64'd0);
        chk("t6_pc",    64'(ifa.pc_o),           64'h1000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_req_a();
        chk("t6_first_addr", 64'(ifa.imem_address_o), 64'h1000);
        exp_a(16'h0100, 32'h0, 32'h1000);
        exp_a(16'h0200, 32'h0, 32'h1002);
        ack_a(32'h0100_0200);
        drain_a("t6_drain");

`ifdef CPU_FETCH_PERF_EN
        // 6a: flush counter
        branch_a(32'h0000_4000);
        step(1);
        branch_a(32'h0000_4000);
        step(1);
        branch_a(32'h0000_4000);
        chk("t6a_flush_cnt", 64'(flush_a), 64'd3);
`endif

        // Address and pc wrap around the top of memory
        wait_req_a();
        branch_a(32'hFFFF_FFFC);
        ack_a(32'h0F0F_0F0F);
        wait_req_a();
        chk("wrap_addr", 64'(ifa.imem_address_o), 64'hFFFF_FFFC);
        exp_a(16'h1234, 32'h0, 32'hFFFF_FFFC);
        exp_a(16'h5678, 32'h0, 32'hFFFF_FFFE);
        ack_a(32'h1234_5678);
        chk("wrap_addr0", 64'(ifa.imem_address_o), 64'h0);
        drain_a("wrap_drain");
        step(1);
        chk("wrap_pc0", 64'(ifa.pc_o), 64'h0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
